// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: delimiter bytes, frame length limits
// and the SFD detector state encoding.
package eth_pkg;

  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD      = 8'hD5;
  localparam int         ETH_MIN_LEN  = 64;
  localparam int         ETH_MAX_LEN  = 1518;
  localparam int         ETH_LEN_W    = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_t;

endpackage

// File: rtl/eth_rx_sfd_detect.sv
// Strips preamble/SFD from a byte-wide PHY receive stream and delivers the frame
// one byte behind the input, flagging sof/eof, length and error on the last byte.
module eth_rx_sfd_detect
  import eth_pkg::*;
#(
  parameter int PRE_MIN = 2,
  parameter int MIN_LEN = ETH_MIN_LEN,
  parameter int MAX_LEN = ETH_MAX_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 phy_rxdv,
  input  logic [7:0]           phy_rxd,
  input  logic                 phy_rxer,
  output logic                 frm_valid,
  output logic [7:0]           frm_data,
  output logic                 frm_sof,
  output logic                 frm_eof,
  output logic                 frm_err,
  output logic [ETH_LEN_W-1:0] frm_len,
  output logic                 frm_drop
);

  localparam logic [3:0]           PRE_MIN_C = 4'(PRE_MIN);
  localparam logic [ETH_LEN_W-1:0] LEN_MIN_C = ETH_LEN_W'(MIN_LEN);
  localparam logic [ETH_LEN_W-1:0] LEN_MAX_C = ETH_LEN_W'(MAX_LEN);

  rx_state_t            state;
  logic [3:0]           pre_cnt;
  logic [ETH_LEN_W-1:0] len;
  logic [ETH_LEN_W-1:0] len_inc;
  logic [7:0]           hold;
  logic                 first;
  logic                 err_flag;

  // Length saturates rather than wrapping so oversized bursts still read as too long.
  assign len_inc = (&len) ? len : len + ETH_LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pre_cnt   <= '0;
      len       <= '0;
      // NOTE: the holding register is reset too, so a discarded frame never leaks a stale byte.
      hold      <= '0;
      first     <= 1'b0;
      err_flag  <= 1'b0;
      frm_valid <= 1'b0;
      frm_data  <= '0;
      frm_sof   <= 1'b0;
      frm_eof   <= 1'b0;
      frm_err   <= 1'b0;
      frm_len   <= '0;
      frm_drop  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; these pulse defaults are overridden later in the same block.
      frm_valid <= 1'b0;
      frm_sof   <= 1'b0;
      frm_eof   <= 1'b0;
      frm_err   <= 1'b0;
      frm_len   <= '0;
      frm_drop  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (phy_rxdv) begin
            if (phy_rxd == ETH_PREAMBLE) begin
              state   <= ST_PREAMBLE;
              pre_cnt <= 4'd1;
            end else begin
              state <= ST_DROP;
            end
          end
        end

        ST_PREAMBLE: begin
          if (!phy_rxdv) begin
            state <= ST_IDLE;
          end else if (phy_rxd == ETH_PREAMBLE) begin
            pre_cnt <= (&pre_cnt) ? pre_cnt : pre_cnt + 4'd1;
          end else if (phy_rxd == ETH_SFD && pre_cnt >= PRE_MIN_C) begin
            state    <= ST_DATA;
            len      <= '0;
            first    <= 1'b1;
            err_flag <= phy_rxer;
          end else begin
            state    <= ST_DROP;
            frm_drop <= 1'b1;
          end
        end

        ST_DATA: begin
          if (phy_rxdv) begin
            len      <= len_inc;
            err_flag <= err_flag | phy_rxer;
            // Past MAX_LEN the held byte is frozen: it becomes the eof byte.
            if (len < LEN_MAX_C) begin
              hold <= phy_rxd;
              if (len != '0) begin
                frm_valid <= 1'b1;
                frm_data  <= hold;
                frm_sof   <= first;
                first     <= 1'b0;
              end
            end
          end else begin
            state <= ST_IDLE;
            if (len == '0) begin
              frm_drop <= 1'b1;
            end else begin
              frm_valid <= 1'b1;
              frm_data  <= hold;
              frm_sof   <= first;
              frm_eof   <= 1'b1;
              frm_len   <= len;
              frm_err   <= err_flag || (len < LEN_MIN_C) || (len > LEN_MAX_C);
              first     <= 1'b0;
            end
          end
        end

        ST_DROP: begin
          if (!phy_rxdv) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_sfd_detect.sv
// Directed bench for eth_rx_sfd_detect: a table of burst scenarios plus
// hand-written back-to-back and mid-frame reset sequences.
module tb_eth_rx_sfd_detect;
  import eth_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 phy_rxdv;
  logic [7:0]           phy_rxd;
  logic                 phy_rxer;
  logic                 frm_valid;
  logic [7:0]           frm_data;
  logic                 frm_sof;
  logic                 frm_eof;
  logic                 frm_err;
  logic [ETH_LEN_W-1:0] frm_len;
  logic                 frm_drop;

  eth_rx_sfd_detect #(.PRE_MIN(2), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk       (clk),
    .rst       (rst),
    .phy_rxdv  (phy_rxdv),
    .phy_rxd   (phy_rxd),
    .phy_rxer  (phy_rxer),
    .frm_valid (frm_valid),
    .frm_data  (frm_data),
    .frm_sof   (frm_sof),
    .frm_eof   (frm_eof),
    .frm_err   (frm_err),
    .frm_len   (frm_len),
    .frm_drop  (frm_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  // Output monitor: frame bytes are expected to count up from 0 after each sof.
  int n_valid, n_sof, n_eof, n_drop, data_bad, flag_bad;
  int last_len, last_err, last_eof_data, sof_cyc, drv_cyc, exp_idx;

  always @(negedge clk) begin
    if (frm_drop) n_drop++;
    if ((frm_sof || frm_eof) && !frm_valid) flag_bad++;
    if (frm_valid) begin
      if (frm_sof) begin
        exp_idx = 0;
        n_sof++;
        sof_cyc = cyc;
      end
      if (frm_data != 8'(exp_idx)) data_bad++;
      exp_idx++;
      n_valid++;
      if (frm_eof) begin
        n_eof++;
        last_len      = int'(frm_len);
        last_err      = int'(frm_err);
        last_eof_data = int'(frm_data);
      end
    end
  end

  task automatic clear_mon();
    n_valid = 0; n_sof = 0; n_eof = 0; n_drop = 0; data_bad = 0; flag_bad = 0;
    last_len = -1; last_err = -1; last_eof_data = -1; sof_cyc = -1; drv_cyc = -1;
    exp_idx = 0;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(posedge clk);
    #1;
    phy_rxdv = dv;
    phy_rxd  = d;
    phy_rxer = er;
  endtask

  task automatic send_frame(input int pre_n, input logic [7:0] sfd, input int n_data,
                            input int er_idx, input int gap);
    for (int i = 0; i < pre_n; i++) drive(1'b1, ETH_PREAMBLE, 1'b0);
    drive(1'b1, sfd, 1'b0);
    for (int i = 0; i < n_data; i++) begin
      drive(1'b1, 8'(i), i == er_idx);
      if (i == 0) drv_cyc = cyc;
    end
    for (int i = 0; i < gap; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    string      name;
    int         pre_n;
    logic [7:0] sfd;
    int         n_data;
    int         er_idx;
    int         exp_valid;
    int         exp_sof;
    int         exp_eof;
    int         exp_len;
    int         exp_err;
    int         exp_drop;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"frame64",      7, 8'hD5,   64, -1,   64, 1, 1,   64, 0, 0};
    vecs[1] = '{"frame64_rxer", 7, 8'hD5,   64, 10,   64, 1, 1,   64, 1, 0};
    vecs[2] = '{"short_pre",    1, 8'hD5,    0, -1,    0, 0, 0,    0, 0, 1};
    vecs[3] = '{"bad_sfd",      2, 8'h12,    0, -1,    0, 0, 0,    0, 0, 1};
    vecs[4] = '{"bad_sfd_data", 2, 8'h12,    5, -1,    0, 0, 0,    0, 0, 1};
    vecs[5] = '{"empty_frame",  2, 8'hD5,    0, -1,    0, 0, 0,    0, 0, 1};
    vecs[6] = '{"one_byte",     2, 8'hD5,    1, -1,    1, 1, 1,    1, 1, 0};
    vecs[7] = '{"len63",        3, 8'hD5,   63, -1,   63, 1, 1,   63, 1, 0};
    vecs[8] = '{"oversize",     7, 8'hD5, 1600, -1, 1518, 1, 1, 1600, 1, 0};

    rst = 1'b1; phy_rxdv = 1'b0; phy_rxd = 8'h00; phy_rxer = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          int'({frm_valid, frm_sof, frm_eof, frm_err, frm_drop, frm_data, frm_len}), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 9; v++) begin
      clear_mon();
      send_frame(vecs[v].pre_n, vecs[v].sfd, vecs[v].n_data, vecs[v].er_idx, 4);
      check({vecs[v].name, "_valid"}, n_valid, vecs[v].exp_valid);
      check({vecs[v].name, "_sof"},   n_sof,   vecs[v].exp_sof);
      check({vecs[v].name, "_eof"},   n_eof,   vecs[v].exp_eof);
      check({vecs[v].name, "_drop"},  n_drop,  vecs[v].exp_drop);
      check({vecs[v].name, "_data"},  data_bad, 0);
      check({vecs[v].name, "_flags"}, flag_bad, 0);
      if (vecs[v].exp_eof != 0) begin
        check({vecs[v].name, "_len"},     last_len, vecs[v].exp_len);
        check({vecs[v].name, "_err"},     last_err, vecs[v].exp_err);
        check({vecs[v].name, "_eofdata"}, last_eof_data, (vecs[v].exp_valid - 1) % 256);
        check({vecs[v].name, "_latency"}, sof_cyc - drv_cyc, 2);
      end
    end

    // Back-to-back frames with a single rxdv-low cycle between them.
    clear_mon();
    send_frame(7, ETH_SFD, 64, -1, 1);
    send_frame(7, ETH_SFD, 64, -1, 4);
    check("b2b_valid", n_valid, 128);
    check("b2b_sof",   n_sof,   2);
    check("b2b_eof",   n_eof,   2);
    check("b2b_data",  data_bad, 0);
    check("b2b_len",   last_len, 64);
    check("b2b_err",   last_err, 0);
    check("b2b_drop",  n_drop,  0);

    // Reset asserted at data byte 30: outputs clear at once and the frame never ends.
    clear_mon();
    send_frame(7, ETH_SFD, 30, -1, 0);
    @(posedge clk);
    #1;
    phy_rxd = 8'd30;
    rst     = 1'b1;
    #1;
    check("midrst_outputs",
          int'({frm_valid, frm_sof, frm_eof, frm_err, frm_drop, frm_data, frm_len}), 0);
    drive(1'b1, 8'd31, 1'b0);
    rst = 1'b0;
    for (int i = 32; i < 36; i++) drive(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0);
    check("midrst_eof", n_eof, 0);

    clear_mon();
    send_frame(7, ETH_SFD, 64, -1, 4);
    check("postrst_valid", n_valid, 64);
    check("postrst_eof",   n_eof,   1);
    check("postrst_len",   last_len, 64);
    check("postrst_err",   last_err, 0);
    check("postrst_data",  data_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_sfd_detect.md
ETH_RX_SFD_DETECT -- requirements
Module: eth_rx_sfd_detect

Interface
REQ-001 SHALL have parameter PRE_MIN, 2, minimum count of 0x55 preamble bytes required before the SFD.
REQ-002 SHALL have parameter MIN_LEN, 64, minimum legal frame length in bytes after the SFD, FCS included.
REQ-003 SHALL have parameter MAX_LEN, 1518, maximum legal frame length in bytes after the SFD, FCS included.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 phy_rxdv  input  1  PHY receive data valid, one byte per clk while high.
REQ-007 phy_rxd  input  8  PHY receive byte.
REQ-008 phy_rxer  input  1  PHY receive error, sampled only while phy_rxdv is high.
REQ-009 frm_valid  output  1  frm_data carries a frame byte this cycle; feeds the downstream receiver data-valid input.
REQ-010 frm_data  output  8  frame byte, destination MAC first; preamble and SFD removed.
REQ-011 frm_sof  output  1  first byte of the frame; asserted only with frm_valid.
REQ-012 frm_eof  output  1  last byte of the frame; asserted only with frm_valid.
REQ-013 frm_err  output  1  frame bad; meaningful only with frm_eof.
REQ-014 frm_len  output  11  bytes after the SFD, saturating at 2047; meaningful only with frm_eof.
REQ-015 frm_drop  output  1  one-cycle pulse when a preamble or SFD fault discards a burst.

Function
REQ-016 SHALL implement states IDLE, PREAMBLE, DATA, DROP.
- IDLE->PREAMBLE: phy_rxdv=1 and phy_rxd=0x55; the preamble count is loaded to 1.
- IDLE->DROP: phy_rxdv=1 and any other byte.
REQ-017 PREAMBLE SHALL behave as follows.
- 0x55: increment the count, saturating at 15.
- 0xD5 with count>=PRE_MIN: go to DATA, length cleared.
- 0xD5 with count<PRE_MIN, or any other byte: go to DROP and pulse frm_drop.
- phy_rxdv=0: return to IDLE silently.
REQ-018 DATA SHALL hold each received byte in a one-byte holding register.
- The byte is emitted on frm_data, registered, in the cycle after the edge that samples the next data byte or phy_rxdv=0.
- Latency is therefore two clocks from phy_rxd to frm_data for every byte except the last.
REQ-019 The first byte emitted after the SFD SHALL carry frm_sof=1.
REQ-020 On the edge where phy_rxdv=0 is sampled in DATA, the held byte SHALL be emitted next cycle with frm_eof=1 and frm_len=byte count; the state returns to IDLE.
REQ-021 frm_err SHALL be 1 on the eof cycle if any of the following holds:
- frm_len<MIN_LEN;
- frm_len>MAX_LEN;
- phy_rxer was sampled high at any time from the SFD up to the end of the frame.
REQ-022 Bytes beyond MAX_LEN SHALL be counted but neither emitted nor stored.
- Byte number MAX_LEN is held and is emitted as the eof byte, with frm_err=1.
REQ-023 If phy_rxdv falls in DATA with zero bytes received after the SFD, nothing SHALL be emitted and frm_drop SHALL pulse.
REQ-024 A frame of exactly 1 byte SHALL emit a single cycle with frm_sof=frm_eof=1 and frm_err=1.
REQ-025 A one-cycle phy_rxdv gap SHALL be sufficient.
- The eof of frame N and the first preamble byte of frame N+1 are handled on consecutive edges without loss.
REQ-026 DROP SHALL ignore all input until phy_rxdv=0 is sampled, then go to IDLE.
REQ-027 frm_valid SHALL never be high for two bytes in one cycle, and never high while the state is PREAMBLE or DROP.
- Exception: the eof output of the previous frame.
REQ-028 The length counter SHALL be 11 bits and saturate at 2047, with no wrap.

Reset
REQ-029 On rst all outputs SHALL go to 0 immediately.
- Covers frm_valid, frm_data, frm_sof, frm_eof, frm_err, frm_len and frm_drop.
- State goes to IDLE; counters, holding register and error flag are cleared.
REQ-030 Reset asserted mid-frame SHALL discard the frame with no eof.
- After release, a burst already in progress is treated by the IDLE rules: a non-0x55 byte leads to DROP.

Structure
REQ-031 A shared package eth_pkg SHALL hold the following:
- the state enumeration;
- the constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, ETH_MIN_LEN=64, ETH_MAX_LEN=1518;
- ETH_LEN_W=11.
REQ-032 The block SHALL be one module without sub-modules.
- The holding register and counters are inline.

Verification
REQ-033 7x0x55, 0xD5, then 64 bytes 0x00..0x3F, then rxdv low -> 64 frm_valid cycles in order.
- sof on 0x00; eof on 0x3F with frm_len=64, frm_err=0.
- First frm_valid two cycles after 0x00 was driven.
REQ-034 Same as REQ-033 with phy_rxer high on data byte 10 -> identical data, eof with frm_err=1.
REQ-035 0x55, 0xD5 with PRE_MIN=2 -> frm_drop pulse, no frm_valid.
- Also 0x55, 0x55, 0x12 -> frm_drop pulse, no frm_valid.
REQ-036 Valid preamble and SFD, then 1600 data bytes -> exactly 1518 frm_valid cycles; the eof byte is byte 1518, frm_len=1600, frm_err=1.
REQ-037 Two 64-byte frames separated by a single rxdv-low cycle -> both delivered intact; eof of the first and preamble of the second are not disturbed.
REQ-038 rst pulsed at data byte 30 -> outputs 0 that cycle, no eof; the next clean frame is delivered correctly.
